// File: rtl/aes_lowarea_pkg.sv
// Shared definitions for the low-area iterative AES datapath stages.
//   STATE_W  : width of the full AES state (128 bits)
//   COL_W    : width of one state column (32 bits)
//   GF_POLY  : low byte of the GF(2^8) field polynomial 0x11b
//   state_e  : two-state sequencing FSM encoding (ST_IDLE / ST_BUSY)
package aes_lowarea_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;

  localparam logic [7:0] GF_POLY = 8'h1b;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mixcolumns_serial_if.sv
// Start/ready handshake bundle shared by the iterative AES stages.
//   start_i   : request, sampled only while the stage is IDLE
//   decrypt_i : 0 = forward transform, 1 = inverse; captured with start_i
//   data_i    : 128-bit input state (byte 0 in [127:120])
//   ready_o   : one-cycle pulse, data_o holds the finished result
//   data_o    : 128-bit result state, same byte ordering as data_i
//
// Handshake: the stage accepts a job on any rising edge where it is IDLE and
// start_i=1; start_i/decrypt_i are ignored while BUSY. ready_o is high for
// exactly one cycle when the result is complete, and data_o keeps that result
// until the next accepted start_i. There is no back-pressure: the consumer
// must sample data_o in the ready_o cycle or later, before the next start.
interface mixcolumns_serial_if;
  import aes_lowarea_pkg::*;

  logic               start_i;
  logic               decrypt_i;
  logic [STATE_W-1:0] data_i;
  logic               ready_o;
  logic [STATE_W-1:0] data_o;

  // master = upstream/round controller side, slave = the stage itself
  modport master (
    output start_i,
    output decrypt_i,
    output data_i,
    input  ready_o,
    input  data_o
  );

  modport slave (
    input  start_i,
    input  decrypt_i,
    input  data_i,
    output ready_o,
    output data_o
  );

endinterface

// File: rtl/mixcolumns_serial_mix_column.sv
// Combinational MixColumns / InvMixColumns of a single 32-bit column.
//   col_i     : input column, row 0 in [31:24]
//   decrypt_i : 0 = forward coefficients {02,03,01,01}, 1 = inverse {0e,0b,0d,09}
//   col_o     : mixed column, row 0 in [31:24]
// All GF(2^8) multiples are built from xtime chains and XORs.
module mix_column
  import aes_lowarea_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  input  logic             decrypt_i,
  output logic [COL_W-1:0] col_o
);

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
  endfunction

  logic [7:0] a  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] m3 [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i]  = col_i[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m3[i] = x2[i] ^ a[i];
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
  end

  logic [COL_W-1:0] fwd_col;
  logic [COL_W-1:0] inv_col;

  // Each output row uses the coefficient vector rotated right by its row index.
  assign fwd_col = {x2[0] ^ m3[1] ^ a[2]  ^ a[3],
                    a[0]  ^ x2[1] ^ m3[2] ^ a[3],
                    a[0]  ^ a[1]  ^ x2[2] ^ m3[3],
                    m3[0] ^ a[1]  ^ a[2]  ^ x2[3]};

  assign inv_col = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                    m9[0] ^ me[1] ^ mb[2] ^ md[3],
                    md[0] ^ m9[1] ^ me[2] ^ mb[3],
                    mb[0] ^ md[1] ^ m9[2] ^ me[3]};

  assign col_o = decrypt_i ? inv_col : fwd_col;

endmodule

// File: rtl/mixcolumns_serial.sv
// Serial AES MixColumns / InvMixColumns stage: one 32-bit column per clock.
//   clk     : rising-edge clock
//   reset   : asynchronous, active-low reset
//   bus     : start/ready handshake and 128-bit data (slave side)
//   state_o : current FSM state (debug)
//   col_o   : current column counter (debug)
// A job accepted at the edge ending cycle N writes columns 0..3 at the edges
// ending N+1..N+4; ready_o pulses during N+5 with the result on data_o.
module mixcolumns_serial
  import aes_lowarea_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  mixcolumns_serial_if.slave  bus,
  output state_e              state_o,
  output logic [1:0]          col_o
);

  state_e             state_q, state_d;
  logic [1:0]         col_q,   col_d;
  logic               dec_q,   dec_d;
  logic [STATE_W-1:0] data_q,  data_d;
  logic               ready_q, ready_d;

  logic [COL_W-1:0]   col_sel;
  logic [COL_W-1:0]   col_mixed;

  // 4:1 column mux feeding the single mixer instance
  always_comb begin
    col_sel = data_q[127:96];
    case (col_q)
      2'd0: col_sel = data_q[127:96];
      2'd1: col_sel = data_q[95:64];
      2'd2: col_sel = data_q[63:32];
      2'd3: col_sel = data_q[31:0];
      default: col_sel = data_q[127:96];
    endcase
  end

  mix_column u_mix_column (
    .col_i     (col_sel),
    .decrypt_i (dec_q),
    .col_o     (col_mixed)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    dec_d   = dec_q;
    data_d  = data_q;
    ready_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          data_d  = bus.data_i;
          dec_d   = bus.decrypt_i;
          col_d   = 2'd0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // write-back demux: only the active column is replaced
        case (col_q)
          2'd0: data_d[127:96] = col_mixed;
          2'd1: data_d[95:64]  = col_mixed;
          2'd2: data_d[63:32]  = col_mixed;
          2'd3: data_d[31:0]   = col_mixed;
          default: data_d = data_q;
        endcase
        if (col_q == 2'd3) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      col_q   <= 2'd0;
      dec_q   <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      dec_q   <= dec_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  assign bus.data_o  = data_q;
  assign bus.ready_o = ready_q;
  assign state_o     = state_q;
  assign col_o       = col_q;

endmodule

// File: tb/tb_mixcolumns_serial.sv
// Self-checking bench for mixcolumns_serial.
module tb_mixcolumns_serial;
  import aes_lowarea_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mixcolumns_serial_if bus ();
  state_e     state_dbg;
  logic [1:0] col_dbg;

  mixcolumns_serial dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_dbg),
    .col_o   (col_dbg)
  );

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] a;
    p = 8'h00;
    a = a_in;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s, input logic dec);
    logic [7:0]   coef [4];
    logic [7:0]   a    [4];
    logic [7:0]   b;
    logic [127:0] r;
    if (dec) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) a[row] = s[127-8*(4*c+row) -: 8];
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b = b ^ gmul(a[k], coef[(k - row + 4) % 4]);
        r[127-8*(4*c+row) -: 8] = b;
      end
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Presents a job and lets one rising edge accept it; the caller guarantees
  // the DUT is IDLE at that edge. Returns 1 ns after the accepting edge.
  task automatic do_start(input logic [127:0] d, input logic dec, input logic [127:0] expv);
    bus.start_i   = 1'b1;
    bus.decrypt_i = dec;
    bus.data_i    = d;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    bus.start_i   = 1'b0;
    bus.decrypt_i = 1'($urandom_range(0, 1));
    bus.data_i    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Counts falling edges until ready_o is seen (bounded).
  task automatic wait_ready(output int lat, output bit found);
    lat   = 0;
    found = 1'b0;
    while (!found && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.ready_o === 1'b1) found = 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset         = 1'b0;
    bus.start_i   = 1'($urandom_range(0, 1));
    bus.decrypt_i = 1'($urandom_range(0, 1));
    bus.data_i    = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) @(negedge clk);
    checks++;
    if (bus.data_o !== 128'h0) begin
      failures++; $display("FAIL reset_data: got %h expected %h", bus.data_o, 128'h0);
    end
    checks++;
    if (bus.ready_o !== 1'b0) begin
      failures++; $display("FAIL reset_ready: got %b expected 0", bus.ready_o);
    end
    checks++;
    if (state_dbg !== ST_IDLE) begin
      failures++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_IDLE);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.ready_o !== 1'b0 || bus.data_o !== 128'h0) begin
        failures++;
        $display("FAIL post_reset_idle: got ready=%b data=%h expected ready=0 data=0", bus.ready_o, bus.data_o);
      end
    end
  endtask

  task automatic test_fips_forward();
    int lat; bit found; logic [127:0] e;
    @(posedge clk); #1;
    do_start(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
             128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    wait_ready(lat, found);
    e = exp_q.pop_front();
    checks++;
    if (!found || lat != 5) begin
      failures++; $display("FAIL fwd_latency: got %0d (found=%0b) expected 5", lat, found);
    end
    checks++;
    if (bus.data_o !== e) begin
      failures++; $display("FAIL fwd_data: got %h expected %h", bus.data_o, e);
    end
    @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b0 || bus.data_o !== e) begin
      failures++; $display("FAIL fwd_hold: got ready=%b data=%h expected ready=0 data=%h", bus.ready_o, bus.data_o, e);
    end
  endtask

  task automatic test_inverse();
    int lat; bit found; logic [127:0] e;
    @(posedge clk); #1;
    do_start(128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 1'b1,
             128'hdb135345_f20a225c_d4d4d4d5_2d26314c);
    wait_ready(lat, found);
    e = exp_q.pop_front();
    checks++;
    if (!found || lat != 5) begin
      failures++; $display("FAIL inv_latency: got %0d (found=%0b) expected 5", lat, found);
    end
    checks++;
    if (bus.data_o !== e) begin
      failures++; $display("FAIL inv_data: got %h expected %h", bus.data_o, e);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit found; logic [127:0] e; logic [127:0] da, db;
    da = {$urandom, $urandom, $urandom, $urandom};
    db = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    do_start(da, 1'b0, mix_model(da, 1'b0));
    // hostile inputs while BUSY: start high, opposite mode
    bus.start_i   = 1'b1;
    bus.decrypt_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_ready(lat, found);
    e = exp_q.pop_front();
    checks++;
    if (!found || lat != 3) begin
      failures++; $display("FAIL b2b_first_latency: got %0d (found=%0b) expected 3", lat, found);
    end
    checks++;
    if (bus.data_o !== e) begin
      failures++; $display("FAIL b2b_first_data: got %h expected %h", bus.data_o, e);
    end
    // second job starts in the ready cycle with the opposite mode
    do_start(db, 1'b1, mix_model(db, 1'b1));
    bus.start_i   = 1'b1;
    bus.decrypt_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_ready(lat, found);
    e = exp_q.pop_front();
    checks++;
    if (!found || lat != 3) begin
      failures++; $display("FAIL b2b_second_latency: got %0d (found=%0b) expected 3", lat, found);
    end
    checks++;
    if (bus.data_o !== e) begin
      failures++; $display("FAIL b2b_second_data: got %h expected %h", bus.data_o, e);
    end
  endtask

  task automatic test_hold_start();
    int lat; bit found; logic [127:0] e; logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    bus.start_i   = 1'b1;
    bus.decrypt_i = 1'b0;
    bus.data_i    = d;
    exp_q.push_back(mix_model(d, 1'b0));
    exp_q.push_back(mix_model(d, 1'b0));
    wait_ready(lat, found);
    e = exp_q.pop_front();
    checks++;
    if (!found || bus.data_o !== e) begin
      failures++; $display("FAIL hold_first: got %h (found=%0b) expected %h", bus.data_o, found, e);
    end
    @(negedge clk);
    bus.start_i = 1'b0;
    checks++;
    if (state_dbg !== ST_BUSY || bus.ready_o !== 1'b0) begin
      failures++; $display("FAIL hold_restart: got state=%0d ready=%b expected state=%0d ready=0", state_dbg, bus.ready_o, ST_BUSY);
    end
    wait_ready(lat, found);
    e = exp_q.pop_front();
    checks++;
    if (!found || lat != 4 || bus.data_o !== e) begin
      failures++; $display("FAIL hold_second: got lat=%0d data=%h expected lat=4 data=%h", lat, bus.data_o, e);
    end
  endtask

  task automatic test_reset_mid_job();
    int lat; bit found; logic [127:0] e; logic [127:0] d;
    bit seen;
    d = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    do_start(d, 1'b0, mix_model(d, 1'b0));
    @(posedge clk); #2;          // now inside cycle N+2
    reset = 1'b0;
    void'(exp_q.pop_front());    // aborted job produces nothing
    #1;
    checks++;
    if (bus.data_o !== 128'h0 || bus.ready_o !== 1'b0 || state_dbg !== ST_IDLE) begin
      failures++;
      $display("FAIL midreset_clear: got data=%h ready=%b state=%0d expected data=0 ready=0 state=0", bus.data_o, bus.ready_o, state_dbg);
    end
    @(negedge clk);
    reset = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.ready_o !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || bus.data_o !== 128'h0) begin
      failures++; $display("FAIL midreset_no_ready: got seen=%0b data=%h expected seen=0 data=0", seen, bus.data_o);
    end
    d = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    do_start(d, 1'b1, mix_model(d, 1'b1));
    wait_ready(lat, found);
    e = exp_q.pop_front();
    checks++;
    if (!found || lat != 5 || bus.data_o !== e) begin
      failures++; $display("FAIL midreset_next_job: got lat=%0d data=%h expected lat=5 data=%h", lat, bus.data_o, e);
    end
  endtask

  task automatic test_round_trip();
    int lat; bit found; logic [127:0] e; logic [127:0] s; logic [127:0] f;
    @(posedge clk); #1;
    for (int n = 0; n < 1000; n++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      f = mix_model(s, 1'b0);
      do_start(s, 1'b0, f);
      wait_ready(lat, found);
      e = exp_q.pop_front();
      checks++;
      if (!found || lat != 5 || bus.data_o !== e) begin
        failures++; $display("FAIL rt_fwd[%0d]: got lat=%0d data=%h expected lat=5 data=%h", n, lat, bus.data_o, e);
      end
      // starting in the ready cycle: a second ready at lat 1 would mean a wide pulse
      do_start(f, 1'b1, s);
      wait_ready(lat, found);
      e = exp_q.pop_front();
      checks++;
      if (!found || lat != 5 || bus.data_o !== e) begin
        failures++; $display("FAIL rt_inv[%0d]: got lat=%0d data=%h expected lat=5 data=%h", n, lat, bus.data_o, e);
      end
      do_start({$urandom, $urandom, $urandom, $urandom}, 1'b0, 128'h0);
      void'(exp_q.pop_back());
      // undo: the extra job above is only to keep throughput pressure; drain it
      wait_ready(lat, found);
      checks++;
      if (!found || lat != 5) begin
        failures++; $display("FAIL rt_filler[%0d]: got lat=%0d expected 5", n, lat);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.ready_o !== 1'b0) begin
      failures++; $display("FAIL rt_pulse_width: got ready=%b expected 0", bus.ready_o);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.start_i   = 1'b0;
    bus.decrypt_i = 1'b0;
    bus.data_i    = '0;
    test_reset();
    test_fips_forward();
    test_inverse();
    test_back_to_back();
    test_hold_start();
    test_reset_mid_job();
    test_round_trip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
